instr_ram_loader: RTL and testbench



---
 rtl/instr_ram_loader.sv | 79 +++++++
 tb/tb_instr_ram_loader.sv | 166 ++++++++++++++++
 2 files changed

// File: rtl/instr_ram_loader.sv
// instr_ram_loader: instruction RAM with a 1-cycle core read port and a byte-stream program loader
module instr_ram_loader #(
  parameter int ADDR_W = 12,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              instr_ram_rd,
  input  logic [ADDR_W-1:0] instr_ram_addr,
  output logic [DATA_W-1:0] instr_ram_din,
  input  logic              load_start,
  input  logic              load_valid,
  input  logic [7:0]        load_data,
  output logic              load_ready,
  input  logic              load_end,
  output logic              core_rst,
  output logic              load_busy,
  output logic [ADDR_W:0]   load_words,
  output logic              load_overflow
);
  typedef enum logic [1:0] {RUN, LOAD, DRAIN} state_t;
  localparam logic [ADDR_W:0] WORDS_MAX = {1'b1, {ADDR_W{1'b0}}};
  state_t state, state_nx;
  logic [DATA_W-1:0] mem [0:(1<<ADDR_W)-1];
  logic [1:0] bcnt, bcnt_nx;
  logic [23:0] part;
  logic [ADDR_W-1:0] waddr;
  logic acc, wr_en;
  logic [DATA_W-1:0] wr_data;
  assign acc     = load_valid & load_ready;
  assign bcnt_nx = bcnt + 2'(acc);
  assign wr_en   = !rst && ((acc && bcnt == 2'd3) || state == DRAIN);
  assign wr_data = (state == DRAIN) ? {8'h00, part} : {load_data, part};
  // state register
  always_ff @(posedge clk)
    if (rst) state <= RUN;
    else state <= state_nx;
  // next state; the end decision uses the byte count after this cycle's byte
  always_comb
    state_nx = (state == RUN)   ? (load_start ? LOAD : RUN) :
               (state == DRAIN) ? RUN :
               (load_end ? ((bcnt_nx == 2'd0) ? RUN : DRAIN) : LOAD);
  // outputs decoded from the registered state, so core_rst changes on the state edges
  always_comb begin
    load_ready = state == LOAD;
    core_rst   = state != RUN;
    load_busy  = state != RUN;
  end
  // byte packing, write address and load statistics
  always_ff @(posedge clk)
    if (rst || (state == RUN && load_start)) begin
      bcnt          <= '0;
      part          <= '0;
      waddr         <= '0;
      load_words    <= '0;
      load_overflow <= 1'b0;
    end else begin
      if (acc) begin
        bcnt <= bcnt_nx;
        part <= (bcnt == 2'd3) ? '0 : part | (24'(load_data) << {bcnt, 3'b000});
      end
      if (state == DRAIN) begin
        bcnt <= '0;
        part <= '0;
      end
      if (wr_en) begin
        waddr      <= waddr + 1'b1;
        load_words <= (load_words == WORDS_MAX) ? load_words : load_words + 1'b1;
        if (waddr == '1) load_overflow <= 1'b1;
      end
    end
  // RAM write port, contents survive reset
  always_ff @(posedge clk)
    if (wr_en) mem[waddr] <= wr_data;
  // core read port, served only while running
  always_ff @(posedge clk)
    if (rst) instr_ram_din <= '0;
    else if (instr_ram_rd && state == RUN) instr_ram_din <= mem[instr_ram_addr];
endmodule

// File: tb/tb_instr_ram_loader.sv
// tb_instr_ram_loader: directed and randomized loads checked against a byte-stream model
module tb_instr_ram_loader;
  localparam int AW = 2;
  localparam int DEPTH = 1 << AW;
  logic clk = 0, rst = 1;
  logic instr_ram_rd = 0;
  logic [AW-1:0] instr_ram_addr = '0;
  logic [31:0] instr_ram_din;
  logic load_start = 0, load_valid = 0, load_end = 0;
  logic [7:0] load_data = '0;
  logic load_ready, core_rst, load_busy, load_overflow;
  logic [AW:0] load_words;
  int checks = 0, errors = 0;
  logic [31:0] mm [DEPTH];
  logic [7:0] bq [$];
  logic [31:0] last_din, wa, wb;
  int exp_words = 0;
  bit exp_ovf = 0;

  instr_ram_loader #(.ADDR_W(AW), .DATA_W(32)) dut (
    .clk(clk), .rst(rst), .instr_ram_rd(instr_ram_rd), .instr_ram_addr(instr_ram_addr),
    .instr_ram_din(instr_ram_din), .load_start(load_start), .load_valid(load_valid),
    .load_data(load_data), .load_ready(load_ready), .load_end(load_end), .core_rst(core_rst),
    .load_busy(load_busy), .load_words(load_words), .load_overflow(load_overflow)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // expected RAM image: the stream is cut into little-endian words written from word 0, wrapping
  task automatic model_apply();
    int n = bq.size();
    int nw = (n + 3) / 4;
    for (int i = 0; i < nw; i++) begin
      logic [31:0] w = '0;
      for (int k = 0; k < 4; k++) if (4 * i + k < n) w[8*k +: 8] = bq[4*i + k];
      mm[i % DEPTH] = w;
    end
    exp_words = (nw > DEPTH) ? DEPTH : nw;
    exp_ovf = nw >= DEPTH;
  endtask

  task automatic send_byte(input logic [7:0] b, input bit e);
    load_valid = 1; load_data = b; load_end = e;
    @(negedge clk);
    load_valid = 0; load_end = 0;
  endtask

  task automatic run_load(input bit end_same, input bit gaps);
    int n = bq.size();
    load_start = 1;
    @(negedge clk);
    load_start = 0;
    chk("start_core_rst", core_rst, 1);
    chk("start_busy", load_busy, 1);
    chk("start_ready", load_ready, 1);
    chk("start_words", load_words, 0);
    chk("start_ovf", load_overflow, 0);
    for (int i = 0; i < n; i++) begin
      if (gaps && $urandom_range(0, 2) == 0) @(negedge clk);
      chk("load_core_rst", core_rst, 1);
      send_byte(bq[i], end_same && i == n - 1);
    end
    if (!(end_same && n > 0)) begin
      load_end = 1;
      @(negedge clk);
      load_end = 0;
    end
    if (n % 4 != 0) begin
      chk("drain_ready", load_ready, 0);
      chk("drain_core_rst", core_rst, 1);
      @(negedge clk);
    end
    chk("end_core_rst", core_rst, 0);
    chk("end_busy", load_busy, 0);
    model_apply();
    chk("end_words", load_words, exp_words);
    chk("end_ovf", load_overflow, exp_ovf);
  endtask

  task automatic rd_chk(input int a);
    instr_ram_addr = AW'(a); instr_ram_rd = 1;
    @(negedge clk);
    instr_ram_rd = 0; instr_ram_addr = AW'(a + 1);
    chk("read", instr_ram_din, mm[a]);
    last_din = mm[a];
    @(negedge clk);
    chk("read_hold", instr_ram_din, last_din);
  endtask

  initial begin
    repeat (3) @(negedge clk);
    rst = 0;
    chk("rst_din", instr_ram_din, 0);
    chk("rst_ready", load_ready, 0);
    chk("rst_core_rst", core_rst, 0);
    chk("rst_busy", load_busy, 0);
    chk("rst_words", load_words, 0);
    chk("rst_ovf", load_overflow, 0);
    bq = '{8'h13, 8'h00, 8'h00, 8'h00, 8'hB7, 8'h10, 8'h00, 8'h00};
    run_load(0, 0);
    chk("dir_mem0", mm[0], 32'h0000_0013);
    chk("dir_mem1", mm[1], 32'h0000_10B7);
    rd_chk(0); rd_chk(1);
    bq = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06};
    run_load(1, 0);
    chk("drain_mem1", mm[1], 32'h0000_0605);
    rd_chk(0); rd_chk(1);
    bq.delete();
    for (int i = 0; i < 20; i++) bq.push_back(8'($urandom));
    run_load(0, 1);
    chk("wrap_words", exp_words, DEPTH);
    for (int a = 0; a < DEPTH; a++) rd_chk(a);
    wa = $urandom; wb = $urandom;
    load_start = 1;
    @(negedge clk);
    load_start = 0;
    chk("restart_ovf", load_overflow, 0);
    chk("restart_words", load_words, 0);
    instr_ram_rd = 1; instr_ram_addr = 1;
    for (int k = 0; k < 4; k++) begin
      send_byte(wa[8*k +: 8], 0);
      chk("load_din_hold", instr_ram_din, last_din);
    end
    load_start = 1;
    @(negedge clk);
    load_start = 0;
    chk("midstart_words", load_words, 1);
    for (int k = 0; k < 4; k++) send_byte(wb[8*k +: 8], 0);
    send_byte(8'hEE, 0);
    chk("mid_words", load_words, 2);
    chk("mid_din_hold", instr_ram_din, last_din);
    instr_ram_rd = 0;
    rst = 1;
    @(negedge clk);
    rst = 0;
    chk("midrst_core_rst", core_rst, 0);
    chk("midrst_busy", load_busy, 0);
    chk("midrst_words", load_words, 0);
    chk("midrst_ready", load_ready, 0);
    chk("midrst_din", instr_ram_din, 0);
    mm[0] = wa; mm[1] = wb;
    exp_words = 0; exp_ovf = 0;
    for (int a = 0; a < DEPTH; a++) rd_chk(a);
    for (int it = 0; it < 12; it++) begin
      load_valid = 1; load_end = 1; load_data = 8'($urandom);
      repeat (2) @(negedge clk);
      load_valid = 0; load_end = 0;
      chk("run_ignore_words", load_words, exp_words);
      chk("run_ignore_ready", load_ready, 0);
      bq.delete();
      repeat ($urandom_range(0, 22)) bq.push_back(8'($urandom));
      run_load(1'($urandom), 1);
      for (int a = 0; a < DEPTH; a++) rd_chk(a);
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
